// File: rtl/elastic_pipeline_ctrl.sv
// Elastic valid/ready staging pipeline with bubble collapse, synchronous flush,
// occupancy reporting and a per-stage stall watchdog with a sticky, clearable error.
module elastic_pipeline_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_STAGES     = 4,
  parameter int TIMEOUT_CYCLES = 10,
  localparam int OCC_W = $clog2(NUM_STAGES + 1),
  localparam int ERR_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  err_clear,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [OCC_W-1:0]      occupancy,
  output logic                  error,
  output logic [ERR_W-1:0]      err_stage
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  if (DATA_WIDTH <= 0 || NUM_STAGES <= 0 || TIMEOUT_CYCLES < 0) begin : g_bad_param
    $fatal(1, "elastic_pipeline_ctrl: illegal parameter value");
  end

  logic [NUM_STAGES-1:0] v_q, v_d;
  logic [DATA_WIDTH-1:0] d_q   [NUM_STAGES];
  logic [DATA_WIDTH-1:0] d_d   [NUM_STAGES];
  logic [CNT_W-1:0]      cnt_q [NUM_STAGES];
  logic [CNT_W-1:0]      cnt_d [NUM_STAGES];
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic                  error_q, error_d;
  logic [ERR_W-1:0]      err_stage_q, err_stage_d;

  logic [NUM_STAGES:0]   rdy_s;
  logic [NUM_STAGES:0]   vin_s;
  logic [DATA_WIDTH-1:0] din_s [NUM_STAGES+1];
  logic                  accept_s;
  logic                  fire_s;
  logic [ERR_W-1:0]      fire_idx_s;

  // Ready chain: a stage may load when it is empty or its successor loads.
  always_comb begin
    rdy_s             = '0;
    rdy_s[NUM_STAGES] = out_ready;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      rdy_s[i] = ~v_q[i] | rdy_s[i+1];
    end
  end

  assign in_ready = rdy_s[0] & ~flush;
  assign accept_s = in_valid & in_ready;

  // Stage advance, flush and next-state occupancy.
  always_comb begin
    vin_s    = {v_q, accept_s};
    din_s[0] = in_data;
    v_d      = v_q;
    occ_d    = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      din_s[i+1] = d_q[i];
    end
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (flush) begin
        v_d[i] = 1'b0;
      end else if (rdy_s[i]) begin
        v_d[i] = vin_s[i];
      end else begin
        v_d[i] = v_q[i];
      end
      // Payload only moves with a valid word so holding registers stay quiet.
      if (rdy_s[i] && vin_s[i]) begin
        d_d[i] = din_s[i];
      end else begin
        d_d[i] = d_q[i];
      end
      occ_d = occ_d + OCC_W'(v_d[i]);
    end
  end

  // Per-stage stall counters; descending scan leaves the lowest firing stage.
  always_comb begin
    fire_s     = 1'b0;
    fire_idx_s = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (TIMEOUT_CYCLES == 0 || flush) begin
        cnt_d[i] = '0;
      end else if (v_q[i] && !rdy_s[i+1]) begin
        cnt_d[i] = (cnt_q[i] == CNT_MAX) ? CNT_MAX : cnt_q[i] + 1'b1;
      end else begin
        cnt_d[i] = '0;
      end
      if (TIMEOUT_CYCLES > 0 && cnt_d[i] == CNT_MAX && cnt_q[i] != CNT_MAX) begin
        fire_s     = 1'b1;
        fire_idx_s = ERR_W'(i);
      end else begin
        fire_s     = fire_s;
      end
    end
  end

  // Sticky error: a fresh timeout beats a simultaneous clear.
  always_comb begin
    error_d     = error_q;
    err_stage_d = err_stage_q;
    if (fire_s) begin
      error_d = 1'b1;
      if (!error_q || err_clear) begin
        err_stage_d = fire_idx_s;
      end else begin
        err_stage_d = err_stage_q;
      end
    end else if (err_clear) begin
      error_d     = 1'b0;
      err_stage_d = '0;
    end else begin
      error_d     = error_q;
      err_stage_d = err_stage_q;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q         <= '0;
      occ_q       <= '0;
      error_q     <= 1'b0;
      err_stage_q <= '0;
      for (int i = 0; i < NUM_STAGES; i++) begin
        d_q[i]   <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      v_q         <= v_d;
      occ_q       <= occ_d;
      error_q     <= error_d;
      err_stage_q <= err_stage_d;
      for (int i = 0; i < NUM_STAGES; i++) begin
        d_q[i]   <= d_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign out_valid = v_q[NUM_STAGES-1];
  assign out_data  = d_q[NUM_STAGES-1];
  assign occupancy = occ_q;
  assign error     = error_q;
  assign err_stage = err_stage_q;

endmodule
